// File: rtl/cms_trace_arbiter.sv
// Two-source round-robin arbiter for the CMS trace stream: grants one source for a
// whole packet of tlast_interval items and drives a registered AXI-Stream output.
module cms_trace_arbiter #(
    parameter int AXI_DATA_WIDTH = 96
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic                      S0_AXIS_tvalid,
    output logic                      S0_AXIS_tready,
    input  logic [AXI_DATA_WIDTH-1:0] S0_AXIS_tdata,

    input  logic                      S1_AXIS_tvalid,
    output logic                      S1_AXIS_tready,
    input  logic [AXI_DATA_WIDTH-1:0] S1_AXIS_tdata,

    output logic                      M_AXIS_tvalid,
    input  logic                      M_AXIS_tready,
    output logic [AXI_DATA_WIDTH-1:0] M_AXIS_tdata,
    output logic                      M_AXIS_tlast,
    output logic                      M_AXIS_tdest,

    input  logic [31:0]               tlast_interval,
    output logic [1:0]                dbg_state
);

    // Handshake rule on every port: an item moves on a rising edge where tvalid and
    // tready are both high; a source holds tvalid/tdata until that edge, and ready
    // never waits on valid from the same side.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic        last_served;
    logic [31:0] pkt_len;
    logic [31:0] cnt;

    logic out_free;
    logic s0_hs;
    logic s1_hs;
    logic load;
    logic beat_last;
    logic grant_start;

    // Output register can take a new item if it is empty or draining this cycle.
    assign out_free       = !M_AXIS_tvalid || M_AXIS_tready;
    assign S0_AXIS_tready = (state == GRANT0) && out_free;
    assign S1_AXIS_tready = (state == GRANT1) && out_free;

    assign s0_hs     = S0_AXIS_tvalid && S0_AXIS_tready;
    assign s1_hs     = S1_AXIS_tvalid && S1_AXIS_tready;
    assign load      = s0_hs || s1_hs;
    assign beat_last = (cnt == pkt_len - 32'd1);

    assign grant_start = (state == IDLE) && (next_state != IDLE);
    assign dbg_state   = state;

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (S0_AXIS_tvalid && S1_AXIS_tvalid) begin
                    // Tie goes to the source that did not own the previous packet.
                    next_state = last_served ? GRANT0 : GRANT1;
                end else if (S0_AXIS_tvalid) begin
                    next_state = GRANT0;
                end else if (S1_AXIS_tvalid) begin
                    next_state = GRANT1;
                end
            end
            GRANT0: begin
                if (s0_hs && beat_last) begin
                    next_state = IDLE;
                end
            end
            GRANT1: begin
                if (s1_hs && beat_last) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Packet bookkeeping: length is frozen at grant so mid-packet interval edits wait.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_len     <= 32'd1;
            cnt         <= 32'd0;
            last_served <= 1'b1;
        end else if (grant_start) begin
            pkt_len <= (tlast_interval == 32'd0) ? 32'd1 : tlast_interval;
            cnt     <= 32'd0;
        end else if (load) begin
            cnt <= cnt + 32'd1;
            if (beat_last) begin
                last_served <= s1_hs;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            M_AXIS_tvalid <= 1'b0;
            M_AXIS_tdata  <= '0;
            M_AXIS_tlast  <= 1'b0;
            M_AXIS_tdest  <= 1'b0;
        end else if (load) begin
            M_AXIS_tvalid <= 1'b1;
            M_AXIS_tdata  <= s1_hs ? S1_AXIS_tdata : S0_AXIS_tdata;
            M_AXIS_tlast  <= beat_last;
            M_AXIS_tdest  <= s1_hs;
        end else if (M_AXIS_tready) begin
            M_AXIS_tvalid <= 1'b0;
        end
    end

endmodule

// File: doc/cms_trace_arbiter.md
# cms_trace_arbiter

Two-source round-robin arbiter sharing the continuous monitoring system's single AXI-Stream trace output toward the host FIFO. Each source (e.g. two monitored cores, or the monitor plus a debug injector) presents fixed-width trace items. The arbiter grants one source for a whole packet of `tlast_interval` items, registers the output and generates `M_AXIS_tlast`/`M_AXIS_tdest`. Packets from the two sources never interleave.

## Interface
- `AXI_DATA_WIDTH`, default 96: width of each trace item (XLEN 64 + 32 instruction bits).
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `S0_AXIS_tvalid`  in  1  source 0 item valid.
- `S0_AXIS_tready`  out  1  source 0 item accepted.
- `S0_AXIS_tdata`  in  AXI_DATA_WIDTH  source 0 item.
- `S1_AXIS_tvalid`  in  1  source 1 item valid.
- `S1_AXIS_tready`  out  1  source 1 item accepted.
- `S1_AXIS_tdata`  in  AXI_DATA_WIDTH  source 1 item.
- `M_AXIS_tvalid`  out  1  output item valid (registered).
- `M_AXIS_tready`  in  1  downstream FIFO ready.
- `M_AXIS_tdata`  out  AXI_DATA_WIDTH  output item (registered).
- `M_AXIS_tlast`  out  1  last item of packet (registered).
- `M_AXIS_tdest`  out  1  source index of current item (registered).
- `tlast_interval`  in  32  items per packet; 0 is treated as 1.

## Operation
- FSM states: IDLE, GRANT0, GRANT1.
- IDLE:
  - `S*_tready`=0.
  - If exactly one source is valid, go to its GRANT state.
  - If both are valid, grant the source not served last. `last_served` resets to 1, so source 0 wins the first tie.
  - On entry to GRANT, latch `pkt_len` = max(`tlast_interval`,1) and clear the beat counter `cnt` (32-bit).
- GRANTn:
  - `Sn_tready` = !M_AXIS_tvalid || M_AXIS_tready. The other source's tready is 0.
  - On an Sn handshake, load the output register: tdata ← Sn_tdata, tdest ← n, tlast ← (cnt == pkt_len-1), tvalid ← 1. Increment `cnt`.
  - On the handshake whose tlast=1: return to IDLE and set `last_served` ← n.
  - A stalled granted source (tvalid low) holds the grant indefinitely. There is no preemption.
- Output register:
  - On M handshake with no new load, tvalid ← 0.
  - Load and drain in the same cycle is allowed. This gives full throughput within a packet.
  - tdata/tlast/tdest hold stable while tvalid=1 and tready=0.
- `tlast_interval` changes mid-packet have no effect until the next grant.
- Sources must hold tdata stable while valid and not ready (AXI-S rule). The arbiter does not check this.

## Timing
- Reset values:
  - M_AXIS_tvalid=0, M_AXIS_tdata=0, M_AXIS_tlast=0, M_AXIS_tdest=0.
  - S0/S1 tready=0.
  - State=IDLE, cnt=0, last_served=1.
- Reset asserted mid-packet: the in-flight output item and the partial packet are discarded. After release the first packet starts at cnt=0.
- Arbitration: one cycle in IDLE. The first item of a packet is accepted at the earliest in the cycle after the source's valid is seen in IDLE.
- Latency: source handshake at edge k → M_AXIS_tvalid high after edge k, i.e. 1 cycle.
- Throughput: 1 item/cycle within a packet. Exactly one bubble cycle (IDLE) between packets.
- With M_AXIS_tready held low, at most one item is buffered and the granted source's tready drops the cycle after the register fills.

## Test plan
- **Single source, interval 3:** S0 streams items 1..6, tready=1 → M emits 1..6 with tdest=0 and tlast on items 3 and 6. There is a 1-cycle gap between items 3 and 4.
- **Both sources always valid, interval 2:** S0 sends A0,A1,…; S1 sends B0,B1,… → output A0,A1(last),B0,B1(last),A2,A3(last). tdest is 0,0,1,1,0,0 and packets never interleave.
- **tlast_interval=0:** every item has tlast=1. Sources alternate item-by-item when both are valid.
- **Backpressure:** M_AXIS_tready=0 for 5 cycles mid-packet → output holds one item stable with tvalid=1. S0_AXIS_tready=0 after the register fills. No item is lost or duplicated once tready returns.
- **Interval change:** change `tlast_interval` from 4 to 2 after item 2 of a packet → that packet still ends at item 4, and the next packet ends after 2 items.
- **Reset mid-packet:** assert rst_n=0 after 2 of 3 items → all outputs go to their reset values asynchronously. After release, S1 alone valid with interval 3 → tlast on its 3rd item and tdest=1.
